// File: rtl/bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_driver
// Purpose  : Converts a 14-bit binary value to four packed BCD digits with a
//            serial double-dabble engine, and drives a 4-digit multiplexed
//            7-segment display (active-low anodes and segments) from the
//            latched result. Values above 9999 are flagged and shown as dashes.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_driver #(
  parameter int REFRESH_DIV = 1000,  // clock cycles each digit is driven
  parameter bit BLANK_LZ    = 1'b1   // 1 = blank leading zeros
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] bin_in,
  output logic [15:0] bcd_out,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [13:0] MAX_BCD    = 14'd9999;
  localparam logic [3:0]  LAST_SHIFT = 4'd13;   // index of the 14th shift cycle
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_DASH   = 7'h3F;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Converter state
  // --------------------------------------------------------------------------
  state_t      state;
  logic [13:0] last_val;
  logic [29:0] sr;        // {bcd[15:0], bin[13:0]} double-dabble working register
  logic [29:0] sr_adj;
  logic [29:0] sr_next;
  logic [3:0]  shift_cnt;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (sr[14 + 4*i +: 4] >= 4'd5) begin
        sr_adj[14 + 4*i +: 4] = sr[14 + 4*i +: 4] + 4'd3;
      end
    end
    sr_next = sr_adj << 1;
  end

  // Converter FSM: detects input changes, runs 14 shift steps, latches result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_val  <= '0;
      bcd_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      sr        <= '0;
      shift_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bin_in != last_val) begin
            last_val <= bin_in;
            if (bin_in > MAX_BCD) begin
              // Out-of-range value is flagged immediately without converting.
              bcd_out <= '0;
              ovf     <= 1'b1;
              done    <= 1'b1;
            end else begin
              sr        <= {16'h0000, bin_in};
              shift_cnt <= '0;
              busy      <= 1'b1;
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // bin_in is deliberately not looked at here; IDLE re-compares later.
          sr        <= sr_next;
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == LAST_SHIFT) begin
            bcd_out <= sr_next[29:14];
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Display multiplexer
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] ref_cnt;
  logic [1:0]       dig_idx;
  logic [1:0]       dig_next;
  logic             ref_wrap;
  logic [3:0]       dig_val;
  logic [3:0]       lead_zero;  // bit k: digit k and all higher digits are zero
  logic [6:0]       seg_sel;

  // Next digit index: advance once per refresh period.
  always_comb begin
    ref_wrap = (ref_cnt == CNT_W'(REFRESH_DIV - 1));
    dig_next = ref_wrap ? (dig_idx + 2'd1) : dig_idx;
  end

  // Segment pattern for the digit that will be enabled next cycle.
  always_comb begin
    lead_zero[3] = (bcd_out[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (bcd_out[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (bcd_out[7:4]  == 4'd0);
    lead_zero[0] = lead_zero[1] && (bcd_out[3:0]  == 4'd0);

    case (dig_next)
      2'd0:    dig_val = bcd_out[3:0];
      2'd1:    dig_val = bcd_out[7:4];
      2'd2:    dig_val = bcd_out[11:8];
      default: dig_val = bcd_out[15:12];
    endcase

    if (ovf) begin
      seg_sel = SEG_DASH;
    end else if (BLANK_LZ && (dig_next != 2'd0) && lead_zero[dig_next]) begin
      // The ones digit is never blanked so a zero value still reads "0".
      seg_sel = SEG_BLANK;
    end else begin
      case (dig_val)
        4'd0:    seg_sel = 7'h40;
        4'd1:    seg_sel = 7'h79;
        4'd2:    seg_sel = 7'h24;
        4'd3:    seg_sel = 7'h30;
        4'd4:    seg_sel = 7'h19;
        4'd5:    seg_sel = 7'h12;
        4'd6:    seg_sel = 7'h02;
        4'd7:    seg_sel = 7'h78;
        4'd8:    seg_sel = 7'h00;
        4'd9:    seg_sel = 7'h10;
        default: seg_sel = SEG_BLANK;
      endcase
    end
  end

  // Refresh counter, digit index and registered anode/segment drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      dig_idx <= 2'd0;
      an_n    <= 4'b1110;
      seg_n   <= 7'h40;
    end else begin
      ref_cnt <= ref_wrap ? '0 : (ref_cnt + CNT_W'(1));
      dig_idx <= dig_next;
      an_n    <= ~(4'b0001 << dig_next);
      seg_n   <= seg_sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_driver
// Purpose  : Self-checking bench for bcd_display_driver. Expected conversion
//            results are queued when stimulus is applied and compared when
//            the design pulses done. Two instances: blanking on and off.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] bin_in;

  logic [15:0] bcd_a, bcd_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {ovf, bcd}
  logic [16:0] sb[$];

  bcd_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bcd_out(bcd_a), .busy(busy_a),
    .done(done_a), .ovf(ovf_a), .an_n(an_a), .seg_n(seg_a)
  );

  bcd_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bcd_out(bcd_b), .busy(busy_b),
    .done(done_b), .ovf(ovf_b), .an_n(an_b), .seg_n(seg_b)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every done pulse must match the oldest queued result.
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (done_a || done_b) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected: done_a=%0b done_b=%0b, required no pending result", done_a, done_b);
      end else begin
        e = sb.pop_front();
        if (done_a !== 1'b1 || done_b !== 1'b1 || bcd_a !== e[15:0] || ovf_a !== e[16] ||
            bcd_b !== e[15:0] || ovf_b !== e[16]) begin
          failures++;
          $display("FAIL result: got bcd_a=%h ovf_a=%0b bcd_b=%h ovf_b=%0b done=%0b/%0b, required bcd=%h ovf=%0b",
                   bcd_a, ovf_a, bcd_b, ovf_b, done_a, done_b, e[15:0], e[16]);
        end
      end
    end
  end

  // Sweep all four digits, comparing segments against {d3,d2,d1,d0} patterns.
  task automatic test_display(input logic [27:0] exp_a, input logic [27:0] exp_b, input string tag);
    int idx;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      case (an_a)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0 || seg_a !== exp_a[7*idx +: 7]) begin
        failures++;
        $display("FAIL disp_a_%s: an_n=%b seg_n=%h, required digit pattern %h", tag, an_a, seg_a,
                 (idx < 0) ? 7'h7F : exp_a[7*idx +: 7]);
      end
      checks++;
      case (an_b)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0 || seg_b !== exp_b[7*idx +: 7]) begin
        failures++;
        $display("FAIL disp_b_%s: an_n=%b seg_n=%h, required digit pattern %h", tag, an_b, seg_b,
                 (idx < 0) ? 7'h7F : exp_b[7*idx +: 7]);
      end
    end
  endtask

  task automatic test_reset();
    int busy_n = 0;
    rst_n  = 1'b0;
    bin_in = 14'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0 || bcd_a !== 16'h0000 ||
        an_a !== 4'b1110 || seg_a !== 7'h40) begin
      failures++;
      $display("FAIL reset_state: busy=%0b done=%0b ovf=%0b bcd=%h an_n=%b seg_n=%h, required 0 0 0 0000 1110 40",
               busy_a, done_a, ovf_a, bcd_a, an_a, seg_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (busy_a) busy_n++;
    end
    checks++;
    if (busy_n != 0 || bcd_a !== 16'h0000) begin
      failures++;
      $display("FAIL reset_no_start: busy cycles=%0d bcd=%h, required 0 cycles and 0000", busy_n, bcd_a);
    end
    test_display({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, "zero");
  endtask

  task automatic test_convert();
    int first_busy = 0, busy_n = 0, done_k = 0, done_n = 0;
    logic [15:0] bcd14 = 16'hxxxx, bcd15 = 16'hxxxx;
    @(negedge clk);
    bin_in = 14'd1234;
    sb.push_back({1'b0, 16'h1234});
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy_a) begin
        busy_n++;
        if (first_busy == 0) first_busy = k;
      end
      if (done_a) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (k == 14) bcd14 = bcd_a;
      if (k == 15) bcd15 = bcd_a;
    end
    checks++;
    if (first_busy != 1 || busy_n != 14) begin
      failures++;
      $display("FAIL conv_busy: first busy at edge %0d for %0d cycles, required edge 1 for 14 cycles", first_busy, busy_n);
    end
    checks++;
    if (bcd14 !== 16'h0000 || bcd15 !== 16'h1234) begin
      failures++;
      $display("FAIL conv_latency: bcd at edge14=%h edge15=%h, required 0000 then 1234", bcd14, bcd15);
    end
    checks++;
    if (done_n != 1 || done_k != 15) begin
      failures++;
      $display("FAIL conv_done: done seen %0d times first after edge %0d, required once after edge 15", done_n, done_k);
    end
    test_display({7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, "1234");
  endtask

  task automatic test_overflow();
    int waited = 0, busy_n = 0, done_k = 0;
    @(negedge clk);
    bin_in = 14'd9999;
    sb.push_back({1'b0, 16'h9999});
    while (sb.size() != 0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL ovf_9999_timeout: pending=%0d after %0d cycles, required 0", sb.size(), waited);
    end
    test_display({7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}, "9999");
    @(negedge clk);
    bin_in = 14'd10000;
    sb.push_back({1'b1, 16'h0000});
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (busy_a) busy_n++;
      if (done_a && done_k == 0) done_k = k;
    end
    checks++;
    if (busy_n != 0 || done_k != 1) begin
      failures++;
      $display("FAIL ovf_timing: busy cycles=%0d done after edge %0d, required 0 cycles and edge 1", busy_n, done_k);
    end
    test_display({7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, "ovf");
  endtask

  task automatic test_back_to_back();
    int done1 = 0, done2 = 0, done_n = 0;
    @(negedge clk);
    bin_in = 14'd1234;
    sb.push_back({1'b0, 16'h1234});
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_a) begin
        done_n++;
        if (done1 == 0) done1 = k;
        else if (done2 == 0) done2 = k;
      end
      if (k == 5) begin
        @(negedge clk);
        bin_in = 14'd42;
        sb.push_back({1'b0, 16'h0042});
      end
    end
    checks++;
    if (done_n != 2 || done1 != 15 || done2 != 30) begin
      failures++;
      $display("FAIL b2b_done: %0d pulses after edges %0d,%0d, required 2 after edges 15,30", done_n, done1, done2);
    end
    test_display({7'h7F, 7'h7F, 7'h19, 7'h24}, {7'h40, 7'h40, 7'h19, 7'h24}, "0042");
  endtask

  task automatic test_refresh();
    logic [3:0] prev;
    logic [3:0] ex;
    bit         found = 0;
    @(negedge clk);
    prev = an_a;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (an_a === 4'b1110 && prev === 4'b0111) found = 1;
      else prev = an_a;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL refresh_sync: an_n=%b, required a 0111->1110 transition within 20 cycles", an_a);
    end
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      ex = 4'b0001 << ((i / 4) % 4);
      ex = ~ex;
      checks++;
      if (an_a !== ex) begin
        failures++;
        $display("FAIL refresh_seq[%0d]: an_n=%b, required %b", i, an_a, ex);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int waited = 0;
    @(negedge clk);
    bin_in = 14'd1234;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy: busy=%0b at shift cycle 7, required 1", busy_a);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || bcd_a !== 16'h0000 || ovf_a !== 1'b0 ||
        an_a !== 4'b1110 || seg_a !== 7'h40) begin
      failures++;
      $display("FAIL rst_mid_state: busy=%0b done=%0b bcd=%h ovf=%0b an_n=%b seg_n=%h, required 0 0 0000 0 1110 40",
               busy_a, done_a, bcd_a, ovf_a, an_a, seg_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back({1'b0, 16'h1234});
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL rst_restart: busy=%0b after first edge out of reset, required 1", busy_a);
    end
    while (sb.size() != 0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (sb.size() != 0 || bcd_a !== 16'h1234) begin
      failures++;
      $display("FAIL rst_reconvert: pending=%0d bcd=%h, required 0 pending and 1234", sb.size(), bcd_a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_back_to_back();
    test_refresh();
    test_reset_mid_shift();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d results never produced, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
